// File: rtl/wb_stage.sv
// Write-back stage: one-entry buffer between the memory stage and the register-file write port.
// Waits for load data, extracts and extends it, and drives the commit signals plus the retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic        flush_i,
    input  logic [63:0] mem_pc_i,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_rd_wen_i,
    input  logic [4:0]  mem_rd_addr_i,
    input  logic [63:0] mem_alu_res_i,
    input  logic        mem_load_i,
    input  logic [2:0]  mem_load_op_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        rf_wen_o,
    output logic [4:0]  rf_addr_o,
    output logic [63:0] rf_wdata_o,
    output logic        commit_valid_o,
    output logic [63:0] commit_pc_o,
    output logic [31:0] commit_inst_o,
    output logic [63:0] instret_o
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [ILEN-1:0]   inst_q, inst_d;
    logic              rd_wen_q, rd_wen_d;
    logic [RW-1:0]     rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              load_q, load_d;
    logic [2:0]        load_op_q, load_op_d;
    logic              ready_q, ready_d;
    logic              rf_wen_q, rf_wen_d;
    logic [RW-1:0]     rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              commit_valid_q, commit_valid_d;
    logic [XLEN-1:0]   commit_pc_q, commit_pc_d;
    logic [ILEN-1:0]   commit_inst_q, commit_inst_d;
    logic [XLEN-1:0]   instret_q, instret_d;

    logic              accept_c;
    logic              wb_next_c;
    logic [XLEN-1:0]   shifted_c;
    logic [XLEN-1:0]   load_val_c;

    assign accept_c = mem_valid_i & ready_q & ~flush_i;

    // Load extraction; the latched ALU result still holds the load address here.
    always_comb begin
        shifted_c = dmem_rdata_i >> {res_q[2:0], 3'b000};
        case (load_op_q)
            3'b000:  load_val_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
            3'b001:  load_val_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
            3'b010:  load_val_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
            3'b100:  load_val_c = {56'd0, shifted_c[7:0]};
            3'b101:  load_val_c = {48'd0, shifted_c[15:0]};
            3'b110:  load_val_c = {32'd0, shifted_c[31:0]};
            default: load_val_c = shifted_c;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        rd_wen_d  = rd_wen_q;
        rd_addr_d = rd_addr_q;
        res_d     = res_q;
        load_d    = load_q;
        load_op_d = load_op_q;
        instret_d = instret_q + XLEN'(state_q == S_WB);

        case (state_q)
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    res_d   = load_val_c;
                    state_d = S_WB;
                end
            end
            default: begin
                // S_IDLE and S_WB both accept; S_WB without a new entry drains to idle.
                if (accept_c) begin
                    pc_d      = mem_pc_i;
                    inst_d    = mem_inst_i;
                    rd_wen_d  = mem_rd_wen_i;
                    rd_addr_d = mem_rd_addr_i;
                    res_d     = mem_alu_res_i;
                    load_d    = mem_load_i;
                    load_op_d = mem_load_op_i;
                    state_d   = mem_load_i ? S_WAIT : S_WB;
                end else begin
                    state_d   = S_IDLE;
                end
            end
        endcase

        wb_next_c      = (state_d == S_WB);
        ready_d        = (state_d != S_WAIT);
        commit_valid_d = wb_next_c;
        rf_wen_d       = wb_next_c & rd_wen_d & (rd_addr_d != RW'(0));
        rf_addr_d      = wb_next_c ? rd_addr_d : RW'(0);
        rf_wdata_d     = wb_next_c ? res_d     : XLEN'(0);
        commit_pc_d    = wb_next_c ? pc_d      : XLEN'(0);
        commit_inst_d  = wb_next_c ? inst_d    : ILEN'(0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            inst_q         <= '0;
            rd_wen_q       <= 1'b0;
            rd_addr_q      <= '0;
            res_q          <= '0;
            load_q         <= 1'b0;
            load_op_q      <= '0;
            ready_q        <= 1'b1;
            rf_wen_q       <= 1'b0;
            rf_addr_q      <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_inst_q  <= '0;
            instret_q      <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inst_q         <= inst_d;
            rd_wen_q       <= rd_wen_d;
            rd_addr_q      <= rd_addr_d;
            res_q          <= res_d;
            load_q         <= load_d;
            load_op_q      <= load_op_d;
            ready_q        <= ready_d;
            rf_wen_q       <= rf_wen_d;
            rf_addr_q      <= rf_addr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_inst_q  <= commit_inst_d;
            instret_q      <= instret_d;
        end
    end

    assign mem_ready_o    = ready_q;
    assign rf_wen_o       = rf_wen_q;
    assign rf_addr_o      = rf_addr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign commit_valid_o = commit_valid_q;
    assign commit_pc_o    = commit_pc_q;
    assign commit_inst_o  = commit_inst_q;
    assign instret_o      = instret_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the in-order RV64 pipeline: a one-entry buffer between the memory stage and the register file's write port. Captures each retiring instruction, waits for load data when needed, extracts and extends the load value, and drives the register-file write port plus difftest commit signals. Maintains a 64-bit retired-instruction counter.

## Interface
Parameters:
- none; XLEN is fixed at 64.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock
- `rst_n` in 1: synchronous active-low reset
- `mem_valid_i` in 1: memory stage offers an instruction
- `mem_ready_o` out 1: stage accepts an offer this cycle
- `flush_i` in 1: suppresses acceptance this cycle; captured entries are unaffected
- `mem_pc_i` in 64: instruction PC
- `mem_inst_i` in 32: instruction word
- `mem_rd_wen_i` in 1: instruction writes rd
- `mem_rd_addr_i` in 5: rd index
- `mem_alu_res_i` in 64: ALU result; load address for loads
- `mem_load_i` in 1: instruction is a load
- `mem_load_op_i` in 3: funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- `dmem_rvalid_i` in 1: load data valid
- `dmem_rdata_i` in 64: 8-byte-aligned doubleword containing the load address
- `rf_wen_o` out 1: register-file write enable
- `rf_addr_o` out 5: register-file write index
- `rf_wdata_o` out 64: register-file write data
- `commit_valid_o` out 1: one instruction retires this cycle
- `commit_pc_o` out 64: retiring PC
- `commit_inst_o` out 32: retiring instruction word
- `instret_o` out 64: retired-instruction count

## Operation
- Accept condition: `mem_valid_i & mem_ready_o & ~flush_i`. Accepting latches pc, inst, rd_wen, rd_addr, alu_res, load, load_op.
- FSM states:
  - `S_IDLE`: accept -> `S_WAIT` if load, else `S_WB`; no accept -> stay in `S_IDLE`.
  - `S_WAIT`: on `dmem_rvalid_i`, latch the extracted load value as the result -> `S_WB`; otherwise stay in `S_WAIT`.
  - `S_WB`: commit cycle. Accept -> `S_WAIT` or `S_WB` per the load flag; no accept -> `S_IDLE`.
- `mem_ready_o` = (state is `S_IDLE` or `S_WB`). It depends only on state, not on `mem_valid_i`.
- Load extraction:
  - off = alu_res[2:0]; shifted = dmem_rdata_i >> (8*off).
  - Take the low 1, 2, 4 or 8 bytes of shifted according to size.
  - lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld uses all 64 bits.
  - Bytes beyond bit 63 read as zero. Misaligned accesses are not trapped here.
  - load_op 111 is treated as ld.
- Result register: alu_res for non-loads; the extracted value for loads.
- In `S_WB` only:
  - `commit_valid_o`=1.
  - `rf_wen_o` = rd_wen & (rd_addr != 0).
  - `rf_addr_o` = rd_addr and `rf_wdata_o` = result. All come straight from flops.
- `commit_valid_o` is asserted for x0 destinations and non-writing instructions too.
- `instret_o` increments by 1 on each `S_WB` cycle; wraps from 2^64-1 to 0.
- Flush: blocks only a new acceptance. An entry in `S_WAIT` or `S_WB` is older than the flusher and always completes.

## Timing
- Reset (synchronous, `rst_n`=0 at a clk edge):
  - State goes to `S_IDLE`; any captured entry is dropped.
  - Outputs `rf_wen_o`, `rf_addr_o`, `rf_wdata_o`, `commit_valid_o`, `commit_pc_o`, `commit_inst_o` and `instret_o` are all 0.
  - `mem_ready_o`=1 from the first cycle after reset.
  - Reset mid-load discards the load; a later `dmem_rvalid_i` in `S_IDLE` is ignored.
- Latency:
  - Non-load accepted at edge N commits in the cycle after edge N (`S_WB`).
  - Load with `dmem_rvalid_i` in cycle k after acceptance commits in cycle k+1.
  - `dmem_rvalid_i` is sampled only in `S_WAIT`, so it can be seen no earlier than the first cycle after acceptance.
- Throughput:
  - Back-to-back non-loads retire one per cycle: `S_WB` accepts and stays in `S_WB`.
  - Every load costs at least 2 cycles.
- The register file bypasses same-cycle writes, so `S_WB` outputs are readable by decode in that same cycle.
- `S_WB` with accept and flush in the same cycle: the current entry commits and the new offer is dropped -> `S_IDLE`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `mem_valid_i`=1 -> all outputs 0, no commit. Release -> `mem_ready_o`=1.
- Back-to-back ALU: 3 non-loads (rd = x5, x6, x7; results 0x11, 0x22, 0x33) offered every cycle -> 3 consecutive commit cycles with matching `rf_addr_o`/`rf_wdata_o`; `instret_o` reads 3 afterwards.
- Load extension: `dmem_rdata_i`=0x8877665544332211.
  - lb at off 7 -> 0xFFFFFFFFFFFFFF88.
  - lbu at off 7 -> 0x88.
  - lh at off 6 -> 0xFFFFFFFFFFFF8877.
  - lw at off 4 -> 0xFFFFFFFF88776655.
  - lwu at off 4 -> 0x88776655.
  - ld at off 0 -> 0x8877665544332211.
- Load stall: load accepted, `dmem_rvalid_i` held low for 4 cycles -> `mem_ready_o`=0 throughout and no commit. rvalid in cycle 5 -> commit in cycle 6.
- x0 and flush:
  - Instruction with rd=x0, rd_wen=1 -> `commit_valid_o`=1 with `rf_wen_o`=0.
  - Offer with `flush_i`=1 -> not accepted, no commit, `instret_o` unchanged.
- Reset while in `S_WAIT`: assert reset, then pulse `dmem_rvalid_i` -> no commit, `instret_o`=0.
